// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RV32/RV64 datapath: FSM states and control encodings.
package mc_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    localparam logic [3:0] AluAnd  = 4'b0000;
    localparam logic [3:0] AluOr   = 4'b0001;
    localparam logic [3:0] AluAdd  = 4'b0010;
    localparam logic [3:0] AluXor  = 4'b0011;
    localparam logic [3:0] AluSll  = 4'b0100;
    localparam logic [3:0] AluSrl  = 4'b0101;
    localparam logic [3:0] AluSub  = 4'b0110;
    localparam logic [3:0] AluSlt  = 4'b0111;
    localparam logic [3:0] AluSra  = 4'b1000;
    localparam logic [3:0] AluSltu = 4'b1001;

    localparam logic [1:0] ImmI  = 2'd0;
    localparam logic [1:0] ImmS  = 2'd1;
    localparam logic [1:0] ImmSb = 2'd2;
    localparam logic [1:0] ImmUj = 2'd3;

    localparam logic [1:0] WbAlu  = 2'd0;
    localparam logic [1:0] WbMem  = 2'd1;
    localparam logic [1:0] WbPc4  = 2'd2;
    localparam logic [1:0] WbNone = 2'd3;

    localparam logic [63:0] DefaultResetPc = 64'h0;

endpackage

// File: rtl/mc_regfile.sv
// 32-entry register file, two asynchronous read ports, one write port, x0 reads as zero.
module mc_regfile #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      raddr_a_i,
    output logic [XLEN-1:0] rdata_a_o,
    input  logic [4:0]      raddr_b_i,
    output logic [XLEN-1:0] rdata_b_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [32];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/my_mc_datapath.sv
// Multi-cycle datapath: FETCH/DECODE/EXEC/MEM/WB sequencing with handshaked instruction
// and data memories. Control inputs come from an external decoder watching inst_out.
module my_mc_datapath
    import mc_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DefaultResetPc)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [31:0]     inst_out,
    input  logic [3:0]      ALU_Control,
    input  logic [1:0]      ImmSel,
    input  logic [1:0]      MemtoReg,
    input  logic            ALUSrc_B,
    input  logic            Jump,
    input  logic            Branch,
    input  logic            InverseBranch,
    input  logic            RegWrite,
    input  logic            JumpReg,
    input  logic            MemRead,
    input  logic            MemWrite,
    output logic [XLEN-1:0] PC_out,
    output logic [XLEN-1:0] ALU_out,
    output logic [2:0]      state_out,
    output logic            retire
);

    localparam int unsigned ShW = $clog2(XLEN);

    state_e state_q, state_d;

    logic [XLEN-1:0] pc_q, a_q, b_q, imm_q, alu_out_q, mdr_q;
    logic [31:0]     ir_q;
    logic            taken_q;

    logic [XLEN-1:0] rs1_data, rs2_data, imm_ext, op_b, alu_res, wb_data;
    logic [XLEN-1:0] pc_plus4, target_base, pc_next;
    logic [ShW-1:0]  shamt;
    logic            zero, taken_now, taken_sel, mem_access, rf_we;
    logic            unused_ir;

    assign unused_ir = ^{ir_q[6:0], ir_q[14:12]};

    mc_regfile #(
        .XLEN (XLEN)
    ) u_regfile (
        .clk_i     (clk),
        .rst_ni    (rst),
        .raddr_a_i (ir_q[19:15]),
        .rdata_a_o (rs1_data),
        .raddr_b_i (ir_q[24:20]),
        .rdata_b_o (rs2_data),
        .we_i      (rf_we),
        .waddr_i   (ir_q[11:7]),
        .wdata_i   (wb_data)
    );

    always_comb begin
        imm_ext = '0;
        case (ImmSel)
            ImmI:    imm_ext = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
            ImmS:    imm_ext = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            ImmSb:   imm_ext = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                                ir_q[11:8], 1'b0};
            default: imm_ext = {{(XLEN-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20],
                                ir_q[30:21], 1'b0};
        endcase
    end

    assign op_b  = ALUSrc_B ? imm_q : b_q;
    assign shamt = op_b[ShW-1:0];

    always_comb begin
        alu_res = '0;
        case (ALU_Control)
            AluAnd:  alu_res = a_q & op_b;
            AluOr:   alu_res = a_q | op_b;
            AluAdd:  alu_res = a_q + op_b;
            AluXor:  alu_res = a_q ^ op_b;
            AluSll:  alu_res = a_q << shamt;
            AluSrl:  alu_res = a_q >> shamt;
            AluSub:  alu_res = a_q - op_b;
            AluSlt:  alu_res[0] = $signed(a_q) < $signed(op_b);
            AluSra:  alu_res = $unsigned($signed(a_q) >>> shamt);
            AluSltu: alu_res[0] = a_q < op_b;
            default: alu_res = '0;
        endcase
    end

    assign zero       = (alu_res == '0);
    assign taken_now  = Jump | JumpReg | (Branch & (zero ^ InverseBranch));
    assign mem_access = MemRead | MemWrite;

    // Branches (and JALR without rd) retire out of EXEC before ALUOut/taken are latched.
    assign taken_sel   = (state_q == StExec) ? taken_now : taken_q;
    assign target_base = (state_q == StExec) ? alu_res : alu_out_q;
    assign pc_plus4    = pc_q + XLEN'(4);

    always_comb begin
        pc_next = pc_plus4;
        if (JumpReg) begin
            pc_next = target_base & {{(XLEN-1){1'b1}}, 1'b0};
        end else if (taken_sel) begin
            pc_next = pc_q + imm_q;
        end
    end

    always_comb begin
        wb_data = alu_out_q;
        case (MemtoReg)
            WbMem:   wb_data = mdr_q;
            WbPc4:   wb_data = pc_plus4;
            default: wb_data = alu_out_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (imem_ready) state_d = StDecode;
            StDecode: state_d = StExec;
            StExec: begin
                if (mem_access)    state_d = StMem;
                else if (RegWrite) state_d = StWb;
                else               state_d = StFetch;
            end
            StMem:    if (dmem_ready) state_d = MemWrite ? StFetch : StWb;
            StWb:     state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    // Requests depend on state (and reset) only, never on the ready inputs.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        retire   = 1'b0;
        rf_we    = 1'b0;
        case (state_q)
            StFetch: imem_req = rst;
            StExec:  retire   = ~mem_access & ~RegWrite;
            StMem: begin
                dmem_req = rst;
                retire   = dmem_ready & MemWrite;
            end
            StWb: begin
                retire = 1'b1;
                rf_we  = RegWrite & (MemtoReg != WbNone);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            taken_q   <= 1'b0;
        end else begin
            if ((state_q == StFetch) && imem_ready) begin
                ir_q <= imem_rdata;
            end
            if (state_q == StDecode) begin
                a_q   <= rs1_data;
                b_q   <= rs2_data;
                imm_q <= imm_ext;
            end
            if (state_q == StExec) begin
                alu_out_q <= alu_res;
                taken_q   <= taken_now;
            end
            if ((state_q == StMem) && dmem_ready && !MemWrite) begin
                mdr_q <= dmem_rdata;
            end
            if (retire) begin
                pc_q <= pc_next;
            end
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_we    = MemWrite;
    assign dmem_addr  = alu_out_q;
    assign dmem_wdata = b_q;
    assign inst_out   = ir_q;
    assign PC_out     = pc_q;
    assign ALU_out    = alu_out_q;
    assign state_out  = state_q;

endmodule

// File: doc/my_mc_datapath.md
# my_mc_datapath

Multi-cycle, parametrised successor to the single-cycle RV32 datapath. Each instruction is sequenced through a FETCH/DECODE/EXEC/MEM/WB state machine, so the block talks to instruction and data memories with request/ready handshakes and tolerates wait states. Branch-condition evaluation is corrected, and register-indirect jumps (JALR) are added. The block sits between the external control unit, which decodes `inst_out`, and the memory/bus fabric.

## Interface
- `XLEN`, 32: datapath, register and address width (32 or 64).
- `RESET_PC`, 0: PC value loaded on reset.
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out XLEN: fetch address, equal to PC.
- `imem_ready` in 1: fetch completes this cycle.
- `imem_rdata` in 32: instruction word, valid when `imem_ready` is high.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_addr` out XLEN: data address, equal to ALUOut.
- `dmem_wdata` out XLEN: store data, equal to the latched rs2 value.
- `dmem_ready` in 1: data access completes this cycle.
- `dmem_rdata` in XLEN: load data.
- `inst_out` out 32: instruction register contents, fed to the control unit.
- `ALU_Control` in 4, `ImmSel` in 2, `MemtoReg` in 2, `ALUSrc_B` in 1, `Jump` in 1, `Branch` in 1, `InverseBranch` in 1, `RegWrite` in 1: control inputs, same meaning as the single-cycle datapath.
- `JumpReg` in 1: JALR. Target is (ALUOut & ~1).
- `MemRead` in 1, `MemWrite` in 1: instruction accesses data memory.
- `PC_out` out XLEN: current PC.
- `ALU_out` out XLEN: ALUOut register.
- `state_out` out 3: FSM state, for debug.
- `retire` out 1: one-cycle pulse when an instruction completes.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- FETCH
  - Drive `imem_req`=1 with `imem_addr`=PC.
  - Stay in FETCH while `imem_ready`=0.
  - On `imem_ready`=1: IR <= `imem_rdata`, go to DECODE.
- DECODE
  - A <= rs1, B <= rs2, IMM <= immgen(IR, ImmSel), sign-extended to XLEN.
  - Go to EXEC.
- EXEC
  - ALUOut <= ALU(A, ALUSrc_B ? IMM : B).
  - taken <= Jump | JumpReg | (Branch & (zero ^ InverseBranch)). `zero` means the ALU result is all-zero.
  - Next state: if MemRead|MemWrite, go to MEM; else if RegWrite, go to WB; else retire and go to FETCH.
- MEM
  - Drive `dmem_req`=1 with `dmem_we`=MemWrite. Address and write data are held stable until `dmem_ready`.
  - On ready: for a load, MDR <= `dmem_rdata` and go to WB; for a store, retire and go to FETCH.
- WB
  - Write data by MemtoReg: 0 = ALUOut, 1 = MDR, 2 = PC+4, 3 = no write.
  - Writes to x0 are dropped.
  - Retire and go to FETCH.
- Retire updates PC and pulses `retire`:
  - JumpReg: PC <= ALUOut & ~1.
  - Otherwise, if taken: PC <= PC + IMM.
  - Otherwise: PC <= PC + 4.
- The control unit decodes `inst_out` combinationally. Control inputs are consumed only from DECODE onward and must hold until retire.
- Arithmetic wraps modulo 2^XLEN. Misaligned targets are not trapped (except JALR bit 0, which is cleared).

## Timing
- Reset (asserted, asynchronous):
  - state=FETCH, PC=`RESET_PC`.
  - IR, A, B, IMM, ALUOut, MDR and all registers = 0.
  - `retire`=0; `dmem_req`=0.
  - `imem_req` is 0 while reset is asserted and goes to 1 on the first cycle after release.
- Request outputs are decoded from state only; there is no combinational path from ready to req.
- Cycle counts with zero wait states: ALU/JAL/JALR = 4, load = 5, store = 4, branch = 3. Each memory wait cycle adds 1.
- Reset mid-access withdraws the request in the same cycle; the memory must accept an abandoned request. A `dmem_ready` arriving after reset is ignored.
- `imem_ready`/`dmem_ready` arriving while the corresponding req is 0 is ignored.
- Register writes and PC update happen on the same edge as the `retire` pulse. The next FETCH sees the updated PC and register file.

## Structure
- Shared package `mc_pkg`:
  - State encoding.
  - ALU_Control opcodes.
  - ImmSel codes (I/S/SB/UJ).
  - MemtoReg codes.
  - Default `RESET_PC`.
- Sub-module `mc_regfile`: XLEN-parametrised, 32 entries, 2 read ports and 1 write port, x0 hardwired to 0, asynchronous active-low reset to 0.
- The ALU and immgen are generalised to XLEN in place (combinational).

## Test plan
- Reset release, zero-wait memory, `addi x1,x0,5` → `imem_addr`=`RESET_PC`, `retire` on cycle 4, x1=5, PC=4.
- `lw x2,0(x1)` with `dmem_ready` delayed 3 cycles and memory word 0xDEADBEEF → `dmem_req` held with stable address 5 for 4 cycles, x2=0xDEADBEEF, 8 cycles total.
- `beq x0,x0,-8` then `bne x0,x0,+8` (InverseBranch=1) → first is taken (PC-8); second is not taken (PC+4), confirming the corrected polarity.
- `jalr x3,7(x1)` with x1=0x100 → PC=0x106, x3 = old PC+4.
- `add x0,x1,x1` → x0 stays 0; `retire` pulses.
- `rst`=0 asserted during a MEM wait → `dmem_req` drops in the same cycle, PC=`RESET_PC`, state=FETCH; a late `dmem_ready` has no effect.
